io_port: RTL and testbench

IO_PORT -- requirements
Module: io_port

---
 rtl/io_pkg.sv | 23 ++
 rtl/byte_fifo.sv | 63 ++++++
 rtl/io_port.sv | 120 ++++++++++++
 tb/tb_io_port.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the CPU I/O port: register-select codes,
// STATUS bit positions and FIFO geometry.
package io_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        RS_DATA    = 2'd0,
        RS_STATUS  = 2'd1,
        RS_SCRATCH = 2'd2,
        RS_MASK    = 2'd3
    } rs_e;

    // STATUS = {0, rx_count[2:0], underflow, overflow, tx_full, rx_nonempty}
    localparam int ST_RX_NE   = 0;
    localparam int ST_TX_FULL = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_UNF     = 3;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/byte_fifo.sv
// 4-entry byte FIFO with flush, head peek and occupancy count.
// Ports: clk, rst, push_i, pop_i, flush_i, data_i -> head_o, count_o, full_o, empty_o.
module byte_fifo
    import io_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [7:0]       data_i,
    output logic [7:0]       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q + PTR_W'(do_push);
        rptr_d = rptr_q + PTR_W'(do_pop);
        cnt_d  = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        // Flush wins over any concurrent push or pop.
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && do_push && !flush_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/io_port.sv
// CPU I/O port: DATA/STATUS/SCRATCH/MASK registers, RX and TX byte FIFOs,
// host valid/ready streams, nsig clear/flush lines and a level irq.
module io_port
    import io_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rd,
    input  logic       wr,
    input  logic [1:0] rs,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [7:0] nsig,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       irq
);

    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic [7:0] scratch_q, scratch_d;
    logic [1:0] mask_q, mask_d;

    logic [7:0]       rx_head, tx_head;
    logic [CNT_W-1:0] rx_cnt, tx_cnt;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             rd_ok, wr_ok, sel_data;
    logic             rx_push, rx_pop, tx_push, tx_pop;
    logic             set_ovf, set_unf;

    // Colliding strobes are treated as no access at all.
    assign rd_ok    = rd & ~wr;
    assign wr_ok    = wr & ~rd;
    assign sel_data = (rs == RS_DATA);

    assign rx_pop  = rd_ok & sel_data & ~rx_empty;
    assign set_unf = rd_ok & sel_data & rx_empty;
    assign tx_push = wr_ok & sel_data & ~tx_full;
    assign set_ovf = wr_ok & sel_data & tx_full;

    assign in_ready  = ~rx_full;
    assign rx_push   = in_valid & in_ready;
    assign out_valid = ~tx_empty;
    assign out_data  = tx_head;
    assign tx_pop    = out_valid & out_ready;

    byte_fifo u_rx (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .flush_i (~nsig[1]),
        .data_i  (in_data),
        .head_o  (rx_head),
        .count_o (rx_cnt),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    byte_fifo u_tx (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .flush_i (~nsig[2]),
        .data_i  (wdata),
        .head_o  (tx_head),
        .count_o (tx_cnt),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    always_comb begin
        // A set event in the same cycle beats the nsig[0] clear.
        ovf_d     = set_ovf | (ovf_q & nsig[0]);
        unf_d     = set_unf | (unf_q & nsig[0]);
        scratch_d = scratch_q;
        mask_d    = mask_q;
        if (wr_ok && rs == RS_SCRATCH) scratch_d = wdata;
        if (wr_ok && rs == RS_MASK)    mask_d    = wdata[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            scratch_q <= 8'h00;
            mask_q    <= 2'b00;
        end else begin
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            scratch_q <= scratch_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        unique case (rs)
            RS_DATA:    rdata = rx_head;
            RS_STATUS: begin
                rdata[ST_CNT_LSB +: 3] = rx_cnt;
                rdata[ST_UNF]          = unf_q;
                rdata[ST_OVF]          = ovf_q;
                rdata[ST_TX_FULL]      = tx_full;
                rdata[ST_RX_NE]        = ~rx_empty;
            end
            RS_SCRATCH: rdata = scratch_q;
            RS_MASK:    rdata = {6'b0, mask_q};
            default:    rdata = 8'h00;
        endcase
    end

    assign irq = (mask_q[0] & ~rx_empty) | (mask_q[1] & (ovf_q | unf_q));

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: table of per-cycle vectors plus
// hand-written full-RX and mid-stream reset sequences.
module tb_io_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd, wr, in_valid, out_ready;
    logic [1:0] rs;
    logic [7:0] wdata, nsig, in_data;
    logic [7:0] rdata, out_data;
    logic       in_ready, out_valid, irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_port dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .wr        (wr),
        .rs        (rs),
        .wdata     (wdata),
        .rdata     (rdata),
        .nsig      (nsig),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .irq       (irq)
    );

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] rs;
        logic [7:0] wdata;
        logic [7:0] nsig;
        logic       iv;
        logic [7:0] idata;
        logic       ordy;
        logic [7:0] e_rdata;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic w, input logic [1:0] s,
                       input logic [7:0] wd, input logic [7:0] ns,
                       input logic iv, input logic [7:0] id, input logic ordy,
                       input logic [7:0] erd, input logic eir,
                       input logic eov, input logic [7:0] eod,
                       input logic eirq);
        vec_t t;
        t = '{r, w, s, wd, ns, iv, id, ordy, erd, eir, eov, eod, eirq};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs away from the rising edge; outputs are
    // sampled 1ns later, before that edge commits the state change.
    task automatic setin(input logic r, input logic w, input logic [1:0] s,
                         input logic [7:0] wd, input logic [7:0] ns,
                         input logic iv, input logic [7:0] id,
                         input logic ordy);
        @(negedge clk);
        rd = r; wr = w; rs = s; wdata = wd; nsig = ns;
        in_valid = iv; in_data = id; out_ready = ordy;
        #1;
    endtask

    task automatic idle(input logic [1:0] s);
        setin(0, 0, s, 8'h00, 8'hFF, 0, 8'h00, 0);
    endtask

    initial begin
        rst = 1'b1;
        rd = 0; wr = 0; rs = 0; wdata = 0; nsig = 8'hFF;
        in_valid = 0; in_data = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);

        //   rd wr rs wdata nsig  iv idata ordy  rdata irdy ov od   irq
        // host bytes 0x11,0x22 then CPU reads
        add(0, 0, 0, 8'h00, 8'hFF, 1, 8'h11, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'hFF, 1, 8'h22, 0, 8'h11, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h11, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h22, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        // underflow, then clear with nsig[0]
        add(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h08, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFE, 0, 8'h00, 0, 8'h08, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        // TX fill past full, then drain
        add(0, 1, 0, 8'hA0, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 1, 0, 8'hA1, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA0, 0);
        add(0, 1, 0, 8'hA2, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA0, 0);
        add(0, 1, 0, 8'hA3, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA0, 0);
        add(0, 1, 0, 8'hA4, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA0, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h06, 1, 1, 8'hA0, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 1, 8'h06, 1, 1, 8'hA0, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 1, 8'h04, 1, 1, 8'hA1, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 1, 8'h04, 1, 1, 8'hA2, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 1, 8'h04, 1, 1, 8'hA3, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h04, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFE, 0, 8'h00, 0, 8'h04, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        // MASK[0] irq and RX flush
        add(0, 1, 3, 8'h01, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 3, 8'h00, 8'hFF, 1, 8'h5A, 0, 8'h01, 1, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'hFD, 0, 8'h00, 0, 8'h5A, 1, 0, 8'h00, 1);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        // MASK[1] irq, rd+wr collision, set beats clear
        add(0, 1, 3, 8'h02, 8'hFF, 0, 8'h00, 0, 8'h01, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h08, 1, 0, 8'h00, 1);
        add(1, 1, 2, 8'h77, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        add(1, 0, 0, 8'h00, 8'hFE, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h08, 1, 0, 8'h00, 1);
        add(0, 0, 1, 8'h00, 8'hFE, 0, 8'h00, 0, 8'h08, 1, 0, 8'h00, 1);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        // SCRATCH, STATUS write ignored, MASK readback
        add(0, 1, 2, 8'hC3, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 2, 8'h00, 8'hFF, 0, 8'h00, 0, 8'hC3, 1, 0, 8'h00, 0);
        add(0, 1, 1, 8'hFF, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 1, 3, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h02, 1, 0, 8'h00, 0);
        // nsig[7:3] ignored, then flush
        add(0, 0, 0, 8'h00, 8'h07, 1, 8'h99, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h07, 0, 8'h00, 0, 8'h99, 1, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'hFD, 0, 8'h00, 0, 8'h99, 1, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            setin(vecs[i].rd, vecs[i].wr, vecs[i].rs, vecs[i].wdata,
                  vecs[i].nsig, vecs[i].iv, vecs[i].idata, vecs[i].ordy);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_in_ready", i), {7'b0, in_ready},
                {7'b0, vecs[i].e_irdy});
            chk($sformatf("v%0d_out_valid", i), {7'b0, out_valid},
                {7'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("v%0d_irq", i), {7'b0, irq},
                {7'b0, vecs[i].e_irq});
        end

        // RX full: concurrent CPU pop and host push -> no push
        setin(0, 0, 0, 8'h00, 8'hFF, 1, 8'hB1, 0);
        setin(0, 0, 0, 8'h00, 8'hFF, 1, 8'hB2, 0);
        setin(0, 0, 0, 8'h00, 8'hFF, 1, 8'hB3, 0);
        setin(0, 0, 0, 8'h00, 8'hFF, 1, 8'hB4, 0);
        idle(1);
        chk("full_status", rdata, 8'h41);
        chk("full_in_ready", {7'b0, in_ready}, 8'h00);
        setin(1, 0, 0, 8'h00, 8'hFF, 1, 8'hEE, 0);
        chk("full_pop_head", rdata, 8'hB1);
        chk("full_pop_in_ready", {7'b0, in_ready}, 8'h00);
        idle(1);
        chk("after_pop_status", rdata, 8'h31);
        // push and pop together at count 3
        setin(1, 0, 0, 8'h00, 8'hFF, 1, 8'hE5, 0);
        chk("pushpop_head", rdata, 8'hB2);
        chk("pushpop_in_ready", {7'b0, in_ready}, 8'h01);
        idle(1);
        chk("pushpop_status", rdata, 8'h31);
        setin(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0);
        chk("drain_b3", rdata, 8'hB3);
        setin(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0);
        chk("drain_b4", rdata, 8'hB4);
        setin(1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0);
        chk("drain_e5", rdata, 8'hE5);
        idle(1);
        chk("drain_status", rdata, 8'h00);

        // Reset mid-stream with 3 bytes in each FIFO
        setin(0, 0, 0, 8'h00, 8'hFF, 1, 8'hC1, 0);
        setin(0, 1, 0, 8'hD1, 8'hFF, 1, 8'hC2, 0);
        setin(0, 1, 0, 8'hD2, 8'hFF, 1, 8'hC3, 0);
        setin(0, 1, 0, 8'hD3, 8'hFF, 0, 8'h00, 0);
        setin(0, 1, 2, 8'h5C, 8'hFF, 0, 8'h00, 0);
        idle(1);
        chk("pre_rst_status", rdata, 8'h31);
        chk("pre_rst_out_data", out_data, 8'hD1);
        setin(0, 1, 0, 8'hE0, 8'hFF, 1, 8'hE1, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        #1;
        chk("post_rst_scratch", rdata, 8'h00);
        chk("post_rst_in_ready", {7'b0, in_ready}, 8'h01);
        chk("post_rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("post_rst_out_data", out_data, 8'h00);
        idle(1);
        chk("post_rst_status", rdata, 8'h00);
        idle(0);
        chk("post_rst_data", rdata, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
